// File: rtl/pe_mac_accum_if.sv
// Beat-state encoding and the PE data-path bundle (build option: PE_MAC_RELU_EN, see pe_mac_accum).
// Latency: none, wiring only.
// Backpressure: none; the PE accepts one beat every cycle.
package pe_mac_pkg;
   typedef enum logic [1:0] {
      INVALID = 2'd0,
      VALID   = 2'd1,
      CNN_FIN = 2'd2
   } pe_state_t;
endpackage

interface pe_mac_accum_if #(
   parameter int DATA_WID = 8,
   parameter int MUL_NUM  = 4,
   parameter int ADDR_B   = 4
);
   import pe_mac_pkg::*;

   pe_state_t                        state_in;
   logic [MUL_NUM-1:0][DATA_WID-1:0] a_in;
   logic [MUL_NUM-1:0]               wrb;
   logic [ADDR_B-1:0]                wrb_addr;
   logic [DATA_WID-1:0]              wrb_data;
   logic [ADDR_B-1:0]                rdb_addr;
   pe_state_t                        state_out;
   logic [DATA_WID-1:0]              data_out;
   logic                             out_valid;
   logic                             acc_ovf;

   // Packet source side
   modport master (
      output state_in, a_in, wrb, wrb_addr, wrb_data, rdb_addr,
      input  state_out, data_out, out_valid, acc_ovf
   );

   // Processing element side
   modport slave (
      input  state_in, a_in, wrb, wrb_addr, wrb_data, rdb_addr,
      output state_out, data_out, out_valid, acc_ovf
   );
endinterface

// File: rtl/pe_mac_accum.sv
// Weight buffer + multiplier lanes + pipelined adder tree + window accumulator; PE_MAC_RELU_EN clamps negative results to 0.
// Latency: 3 + log2(MUL_NUM) cycles from state_in sampled to out_valid / state_out.
// Backpressure: none; one beat per cycle, CNN_FIN may be followed directly by the next window.
module pe_mac_accum
   import pe_mac_pkg::*;
#(
   parameter int DATA_WID  = 8,
   parameter int MUL_NUM   = 4,
   parameter int ADDR_B    = 4,
   parameter int ACC_WID   = 24,
   parameter int OUT_SHIFT = 0
) (
   input  logic          clk,
   input  logic          reset,
   pe_mac_accum_if.slave io
);

   localparam int LVL     = $clog2(MUL_NUM);
   localparam int SUM_WID = 2 * DATA_WID + LVL;
   localparam int NST     = LVL + 2;   // state stages ahead of the final stage
   localparam int DEPTH   = 2 ** ADDR_B;

   localparam logic signed [ACC_WID-1:0]  ACC_MAX = {1'b0, {(ACC_WID-1){1'b1}}};
   localparam logic signed [ACC_WID-1:0]  ACC_MIN = {1'b1, {(ACC_WID-1){1'b0}}};
   localparam logic [DATA_WID-1:0]        OUT_MAX = {1'b0, {(DATA_WID-1){1'b1}}};
   localparam logic [DATA_WID-1:0]        OUT_MIN = {1'b1, {(DATA_WID-1){1'b0}}};

   // Weight storage, one bank per lane
   logic [DATA_WID-1:0] wbuf_q [MUL_NUM][DEPTH];

   // Stage 1: activations, weights
   logic [DATA_WID-1:0] a_d [MUL_NUM];
   logic [DATA_WID-1:0] a_q [MUL_NUM];
   logic [DATA_WID-1:0] w_d [MUL_NUM];
   logic [DATA_WID-1:0] w_q [MUL_NUM];

   // Products and adder tree in heap order: leaves MUL_NUM..2*MUL_NUM-1 hold
   // the products, node n sums nodes 2n and 2n+1, node 1 is the root. Every
   // node is registered, so each tree level is one pipeline stage. Nodes are
   // stored at the full tree width; level l values only ever occupy
   // 2*DATA_WID+l bits, so the tree cannot overflow.
   logic signed [SUM_WID-1:0] node_d [1:2*MUL_NUM-1];
   logic signed [SUM_WID-1:0] node_q [1:2*MUL_NUM-1];

   // Beat qualifier travelling alongside the data
   pe_state_t st_d [NST];
   pe_state_t st_q [NST];

   // Final stage
   logic signed [ACC_WID-1:0] acc_d, acc_q;
   logic                      flag_d, flag_q;
   logic [DATA_WID-1:0]       data_out_d, data_out_q;
   logic                      out_valid_d, out_valid_q;
   logic                      acc_ovf_d, acc_ovf_q;
   pe_state_t                 state_out_d, state_out_q;

   // Final stage intermediates
   logic [ACC_WID:0]               acc_sum;
   logic signed [ACC_WID-1:0]      acc_sat;
   logic signed [ACC_WID-1:0]      acc_shr;
   logic [ACC_WID-DATA_WID:0]      out_hi;
   logic                           acc_clamp;
   logic                           out_clamp;
   logic [DATA_WID-1:0]            out_val;

   // Weight write; a same-cycle read of the address sees the previous value
   always_ff @(posedge clk) begin
      for (int k = 0; k < MUL_NUM; k++) begin
         if (io.wrb[k]) wbuf_q[k][io.wrb_addr] <= io.wrb_data;
      end
   end

   // Stage 1 inputs, products, tree sums and the state shift chain
   always_comb begin
      for (int k = 0; k < MUL_NUM; k++) begin
         a_d[k] = io.a_in[k];
         w_d[k] = wbuf_q[k][io.rdb_addr];
         node_d[MUL_NUM+k] =
            $signed({{(SUM_WID-DATA_WID){a_q[k][DATA_WID-1]}}, a_q[k]}) *
            $signed({{(SUM_WID-DATA_WID){w_q[k][DATA_WID-1]}}, w_q[k]});
      end
      for (int n = 1; n < MUL_NUM; n++) begin
         node_d[n] = node_q[2*n] + node_q[2*n+1];
      end
      st_d[0] = io.state_in;
      for (int i = 1; i < NST; i++) begin
         st_d[i] = st_q[i-1];
      end
      state_out_d = st_q[NST-1];
   end

   // Accumulate the root sum, saturate, shift and clamp to the output width
   always_comb begin
      acc_sum   = {acc_q[ACC_WID-1], acc_q} +
                  {{(ACC_WID+1-SUM_WID){node_q[1][SUM_WID-1]}}, node_q[1]};
      acc_clamp = acc_sum[ACC_WID] ^ acc_sum[ACC_WID-1];
      acc_sat   = acc_clamp ? (acc_sum[ACC_WID] ? ACC_MIN : ACC_MAX)
                            : acc_sum[ACC_WID-1:0];
      acc_shr   = acc_sat >>> OUT_SHIFT;
      out_hi    = acc_shr[ACC_WID-1:DATA_WID-1];
      out_clamp = !((&out_hi) || !(|out_hi));
      out_val   = out_clamp ? (acc_shr[ACC_WID-1] ? OUT_MIN : OUT_MAX)
                            : acc_shr[DATA_WID-1:0];
`ifdef PE_MAC_RELU_EN
      // The ReLU clamp does not count as saturation
      if (out_val[DATA_WID-1]) out_val = '0;
`else
`endif

      acc_d       = acc_q;
      flag_d      = flag_q;
      data_out_d  = data_out_q;
      out_valid_d = 1'b0;
      acc_ovf_d   = 1'b0;
      case (st_q[NST-1])
         VALID: begin
            acc_d  = acc_sat;
            flag_d = flag_q | acc_clamp;
         end
         CNN_FIN: begin
            data_out_d  = out_val;
            out_valid_d = 1'b1;
            acc_ovf_d   = flag_q | acc_clamp | out_clamp;
            acc_d       = '0;
            flag_d      = 1'b0;
         end
         default: begin
            // INVALID (and the unused encoding) is a bubble: hold everything
         end
      endcase
   end

   // Pipeline, accumulator and output registers; weights are not reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < MUL_NUM; k++) begin
            a_q[k] <= '0;
            w_q[k] <= '0;
         end
         for (int n = 1; n < 2 * MUL_NUM; n++) begin
            node_q[n] <= '0;
         end
         for (int i = 0; i < NST; i++) begin
            st_q[i] <= INVALID;
         end
         state_out_q <= INVALID;
         acc_q       <= '0;
         flag_q      <= 1'b0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         acc_ovf_q   <= 1'b0;
      end else begin
         a_q         <= a_d;
         w_q         <= w_d;
         node_q      <= node_d;
         st_q        <= st_d;
         state_out_q <= state_out_d;
         acc_q       <= acc_d;
         flag_q      <= flag_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         acc_ovf_q   <= acc_ovf_d;
      end
   end

   assign io.state_out = state_out_q;
   assign io.data_out  = data_out_q;
   assign io.out_valid = out_valid_q;
   assign io.acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_pe_mac_accum.sv
// Bench for pe_mac_accum: two instances (OUT_SHIFT 0 and 6) driven with the same beats.
// Latency: expects each result exactly 5 cycles after its CNN_FIN beat.
// Backpressure: none; beats are driven every cycle from the falling edge.
`timescale 1ns/1ps
module tb_pe_mac_accum;
   import pe_mac_pkg::*;

   localparam int DW = 8;
   localparam int MN = 4;
   localparam int AB = 4;

   typedef struct {
      int data;
      bit ovf;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   pulses0 = 0;
   int   pulses6 = 0;

   // Reference state: weight image and running window sum
   int     wm [MN][16];
   longint acc_m = 0;
   exp_t   q0[$];
   exp_t   q6[$];
   exp_t   e0, e6;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pe_mac_accum_if #(.DATA_WID(DW), .MUL_NUM(MN), .ADDR_B(AB)) if0 ();
   pe_mac_accum_if #(.DATA_WID(DW), .MUL_NUM(MN), .ADDR_B(AB)) if6 ();

   assign if6.state_in = if0.state_in;
   assign if6.a_in     = if0.a_in;
   assign if6.wrb      = if0.wrb;
   assign if6.wrb_addr = if0.wrb_addr;
   assign if6.wrb_data = if0.wrb_data;
   assign if6.rdb_addr = if0.rdb_addr;

   pe_mac_accum #(.DATA_WID(DW), .MUL_NUM(MN), .ADDR_B(AB), .ACC_WID(24), .OUT_SHIFT(0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .io    (if0)
   );

   pe_mac_accum #(.DATA_WID(DW), .MUL_NUM(MN), .ADDR_B(AB), .ACC_WID(24), .OUT_SHIFT(6)) dut6 (
      .clk   (clk),
      .reset (reset),
      .io    (if6)
   );

   function automatic exp_t mk_exp(input longint s, input int sh, input int c);
      exp_t   e;
      longint r;
      r = s >>> sh;
      e.ovf = 1'b0;
      if (r > 127) begin
         r = 127;
         e.ovf = 1'b1;
      end else if (r < -128) begin
         r = -128;
         e.ovf = 1'b1;
      end
`ifdef PE_MAC_RELU_EN
      if (r < 0) r = 0;
`endif
      e.data = int'(r);
      e.cyc  = c;
      return e;
   endfunction

   // One beat: drive at the falling edge, update the reference, queue results
   task automatic beat(input pe_state_t s, input int a0, input int a1, input int a2, input int a3,
                       input int ra, input logic [3:0] we, input int wa, input int wd);
      int     av [MN];
      longint bsum;
      av = '{a0, a1, a2, a3};
      @(negedge clk);
      if0.state_in = s;
      for (int k = 0; k < MN; k++) if0.a_in[k] = DW'(av[k]);
      if0.rdb_addr = AB'(ra);
      if0.wrb      = we;
      if0.wrb_addr = AB'(wa);
      if0.wrb_data = DW'(wd);
      bsum = 0;
      if (s != INVALID) begin
         for (int k = 0; k < MN; k++) bsum += longint'(av[k]) * longint'(wm[k][ra]);
      end
      for (int k = 0; k < MN; k++) if (we[k]) wm[k][wa] = wd;
      if (s == VALID) begin
         acc_m += bsum;
      end else if (s == CNN_FIN) begin
         q0.push_back(mk_exp(acc_m + bsum, 0, cyc + 5));
         q6.push_back(mk_exp(acc_m + bsum, 6, cyc + 5));
         acc_m = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(INVALID, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
   endtask

   // Scoreboard: every out_valid pulse must match the oldest queued result
   always @(negedge clk) begin
      if (reset === 1'b0 && if0.out_valid === 1'b1) begin
         pulses0 = pulses0 + 1;
         checks = checks + 1;
         if (q0.size() == 0) begin
            errors = errors + 1;
            $display("FAIL spurious_pulse0 cycle %0d data %0d", cyc, $signed(if0.data_out));
         end else begin
            e0 = q0.pop_front();
            checks = checks + 3;
            if (if0.data_out !== DW'(e0.data)) begin
               errors = errors + 1;
               $display("FAIL data0 got %0d want %0d", $signed(if0.data_out), e0.data);
            end
            if (if0.acc_ovf !== e0.ovf) begin
               errors = errors + 1;
               $display("FAIL ovf0 got %b want %b", if0.acc_ovf, e0.ovf);
            end
            if (cyc != e0.cyc) begin
               errors = errors + 1;
               $display("FAIL latency0 got cycle %0d want cycle %0d", cyc, e0.cyc);
            end
         end
      end
      if (reset === 1'b0 && if6.out_valid === 1'b1) begin
         pulses6 = pulses6 + 1;
         checks = checks + 1;
         if (q6.size() == 0) begin
            errors = errors + 1;
            $display("FAIL spurious_pulse6 cycle %0d data %0d", cyc, $signed(if6.data_out));
         end else begin
            e6 = q6.pop_front();
            checks = checks + 3;
            if (if6.data_out !== DW'(e6.data)) begin
               errors = errors + 1;
               $display("FAIL data6 got %0d want %0d", $signed(if6.data_out), e6.data);
            end
            if (if6.acc_ovf !== e6.ovf) begin
               errors = errors + 1;
               $display("FAIL ovf6 got %b want %b", if6.acc_ovf, e6.ovf);
            end
            if (cyc != e6.cyc) begin
               errors = errors + 1;
               $display("FAIL latency6 got cycle %0d want cycle %0d", cyc, e6.cyc);
            end
         end
      end
   end

   task automatic test_reset();
      if0.state_in = INVALID;
      if0.a_in     = '0;
      if0.wrb      = '0;
      if0.wrb_addr = '0;
      if0.wrb_data = '0;
      if0.rdb_addr = '0;
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks = checks + 4;
      if (if0.data_out !== 8'd0 || if6.data_out !== 8'd0) begin
         errors = errors + 1;
         $display("FAIL reset_data got %0d/%0d want 0", if0.data_out, if6.data_out);
      end
      if (if0.out_valid !== 1'b0 || if6.out_valid !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL reset_valid got %b/%b want 0", if0.out_valid, if6.out_valid);
      end
      if (if0.acc_ovf !== 1'b0 || if6.acc_ovf !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL reset_ovf got %b/%b want 0", if0.acc_ovf, if6.acc_ovf);
      end
      if (if0.state_out !== INVALID || if6.state_out !== INVALID) begin
         errors = errors + 1;
         $display("FAIL reset_state got %0d/%0d want INVALID", if0.state_out, if6.state_out);
      end
      reset = 1'b0;
   endtask

   task automatic test_window();
      for (int i = 0; i < 9; i++) beat(INVALID, 0, 0, 0, 0, 0, 4'b1111, i, i + 1);
      for (int i = 0; i < 9; i++)
         beat((i == 8) ? CNN_FIN : VALID, i, 16 + i, 32 + i, 48 + i, i, 4'b0000, 0, 0);
      idle(7);
      // Raw window sum is 5280: saturates at shift 0, 82 at shift 6
      checks = checks + 2;
      if (if0.data_out !== 8'd127) begin
         errors = errors + 1;
         $display("FAIL window_shift0 got %0d want 127", $signed(if0.data_out));
      end
      if (if6.data_out !== 8'd82) begin
         errors = errors + 1;
         $display("FAIL window_shift6 got %0d want 82", $signed(if6.data_out));
      end
   endtask

   task automatic test_negative();
      logic [7:0] want;
`ifdef PE_MAC_RELU_EN
      want = 8'd0;
`else
      want = 8'hFC;
`endif
      beat(INVALID, 0, 0, 0, 0, 0, 4'b1111, 0, -1);
      beat(CNN_FIN, 1, 1, 1, 1, 0, 4'b0000, 0, 0);
      idle(7);
      checks = checks + 1;
      if (if0.data_out !== want) begin
         errors = errors + 1;
         $display("FAIL negative got %0d want %0d", $signed(if0.data_out), $signed(want));
      end
   endtask

   task automatic test_back_to_back();
      int p0;
      beat(INVALID, 0, 0, 0, 0, 0, 4'b1111, 10, 1);
      p0 = pulses0;
      beat(CNN_FIN, 1, 2, 3, 4, 10, 4'b0000, 0, 0);
      beat(VALID,   3, 0, 0, 0, 10, 4'b0000, 0, 0);
      beat(CNN_FIN, 1, 1, 1, 1, 10, 4'b0000, 0, 0);
      idle(8);
      checks = checks + 2;
      if (pulses0 - p0 != 2) begin
         errors = errors + 1;
         $display("FAIL b2b_pulses got %0d want 2", pulses0 - p0);
      end
      if (if0.data_out !== 8'd7) begin
         errors = errors + 1;
         $display("FAIL b2b_second got %0d want 7", $signed(if0.data_out));
      end
   endtask

   task automatic test_bubbles();
      int p0;
      p0 = pulses0;
      beat(VALID,   5, 0, 0, 0, 10, 4'b0000, 0, 0);
      beat(INVALID, 0, 0, 0, 0, 10, 4'b0000, 0, 0);
      beat(INVALID, 0, 0, 0, 0, 10, 4'b0000, 0, 0);
      beat(CNN_FIN, 5, 0, 0, 0, 10, 4'b0000, 0, 0);
      idle(7);
      checks = checks + 2;
      if (pulses0 - p0 != 1) begin
         errors = errors + 1;
         $display("FAIL bubbles_pulses got %0d want 1", pulses0 - p0);
      end
      if (if0.data_out !== 8'd10) begin
         errors = errors + 1;
         $display("FAIL bubbles_data got %0d want 10", $signed(if0.data_out));
      end
   endtask

   task automatic test_collision();
      int p0;
      beat(INVALID, 0, 0, 0, 0, 0, 4'b1111, 3, 2);
      p0 = pulses0;
      beat(CNN_FIN, 1, 1, 1, 1, 3, 4'b1111, 3, 9);
      beat(CNN_FIN, 1, 1, 1, 1, 3, 4'b0000, 0, 0);
      idle(7);
      checks = checks + 2;
      if (pulses0 - p0 != 2) begin
         errors = errors + 1;
         $display("FAIL collision_pulses got %0d want 2", pulses0 - p0);
      end
      if (if0.data_out !== 8'd36) begin
         errors = errors + 1;
         $display("FAIL collision_repeat got %0d want 36", $signed(if0.data_out));
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      p0 = pulses0;
      for (int i = 0; i < 5; i++) beat(VALID, 1, 1, 1, 1, 10, 4'b0000, 0, 0);
      beat(INVALID, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
      checks = checks + 1;
      if (if0.state_out !== VALID) begin
         errors = errors + 1;
         $display("FAIL midwin_state got %0d want VALID", if0.state_out);
      end
      #2 reset = 1'b1;
      acc_m = 0;
      #1;
      checks = checks + 3;
      if (if0.data_out !== 8'd0) begin
         errors = errors + 1;
         $display("FAIL midreset_data got %0d want 0", $signed(if0.data_out));
      end
      if (if0.state_out !== INVALID || if6.state_out !== INVALID) begin
         errors = errors + 1;
         $display("FAIL midreset_state got %0d/%0d want INVALID", if0.state_out, if6.state_out);
      end
      if (if0.out_valid !== 1'b0 || if0.acc_ovf !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL midreset_flags got %b%b want 00", if0.out_valid, if0.acc_ovf);
      end
      @(negedge clk);
      reset = 1'b0;
      beat(CNN_FIN, 6, 0, 0, 0, 10, 4'b0000, 0, 0);
      idle(7);
      checks = checks + 2;
      if (pulses0 - p0 != 1) begin
         errors = errors + 1;
         $display("FAIL midreset_pulses got %0d want 1", pulses0 - p0);
      end
      if (if0.data_out !== 8'd6) begin
         errors = errors + 1;
         $display("FAIL midreset_after got %0d want 6", $signed(if0.data_out));
      end
   endtask

   initial begin
      test_reset();
      idle(2);
      test_window();
      test_negative();
      test_back_to_back();
      test_bubbles();
      test_collision();
      test_reset_mid();
      idle(4);
      checks = checks + 2;
      if (q0.size() != 0) begin
         errors = errors + 1;
         $display("FAIL missing_results0 got %0d pending want 0", q0.size());
      end
      if (q6.size() != 0) begin
         errors = errors + 1;
         $display("FAIL missing_results6 got %0d pending want 0", q6.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
